// File: rtl/mux2_pkg.sv
// Shared definitions for the mux2 datapath and its round-robin stream merger.
//   SEL_I0 / SEL_I1 : select encodings of the mux2 cell (and of the exported j).
//   burst_w()       : width of a burst counter able to hold 0..max_burst.
package mux2_pkg;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  function automatic int unsigned burst_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 mux cell of the existing datapath.
//   i0 : input selected when j = SEL_I0
//   i1 : input selected when j = SEL_I1
//   j  : select
//   o  : selected bit
module mux2
  import mux2_pkg::*;
(
  input  logic i0,
  input  logic i1,
  input  logic j,
  output logic o
);

  assign o = (j == SEL_I1) ? i1 : i0;

endmodule

// File: rtl/mux2_rr_merge_mux.sv
// WIDTH-bit steering array built from mux2 cells sharing one select.
//   i_d0  : channel 0 word
//   i_d1  : channel 1 word
//   i_sel : shared select (0 = i_d0, 1 = i_d1)
//   o_d   : steered word
module mux2_rr_merge_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_d
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    mux2 u_mux2 (
      .i0 (i_d0[g]),
      .i1 (i_d1[g]),
      .j  (i_sel),
      .o  (o_d[g])
    );
  end

endmodule

// File: rtl/mux2_rr_merge.sv
// Two-input valid/ready merger: round-robin arbitration with a bounded burst
// allowance, winner steered through the mux2 array into one output register.
//   clk, rst_n            : clock, synchronous active-low reset
//   i0_data/valid/ready   : channel 0 stream
//   i1_data/valid/ready   : channel 1 stream
//   o_data/valid, o_ready : merged output stream (registered slot)
//   j                     : registered source of o_data (0 = ch0, 1 = ch1)
module mux2_rr_merge
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  output logic             i1_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             j
);

  localparam int unsigned    BW        = burst_w(MAX_BURST);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_j;
  logic [BW-1:0]    r_burst;

  logic             w_free;
  logic             w_pick;
  logic             w_pick_valid;
  logic             w_xfer;
  logic [BW-1:0]    w_burst_nxt;
  logic [WIDTH-1:0] w_mux_data;

  // Slot can take a word if empty or being drained this same cycle.
  assign w_free = !r_valid || o_ready;

  // Arbitration: lone requester wins; with both requesting, the owner keeps
  // the grant until its burst allowance is used up.
  always_comb begin
    w_pick = r_j;
    if (i0_valid && i1_valid) begin
      w_pick = (r_burst >= BURST_MAX) ? !r_j : r_j;
    end else if (i0_valid) begin
      w_pick = SEL_I0;
    end else if (i1_valid) begin
      w_pick = SEL_I1;
    end
  end

  assign w_pick_valid = (w_pick == SEL_I1) ? i1_valid : i0_valid;
  assign w_xfer       = w_free && w_pick_valid;

  // Same owner extends its run (saturating); a new owner starts at 1.
  always_comb begin
    w_burst_nxt = BW'(1);
    if (w_pick == r_j) begin
      w_burst_nxt = (r_burst >= BURST_MAX) ? BURST_MAX : r_burst + BW'(1);
    end
  end

  assign i0_ready = rst_n && w_free && (w_pick == SEL_I0);
  assign i1_ready = rst_n && w_free && (w_pick == SEL_I1);

  mux2_rr_merge_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_d0  (i0_data),
    .i_d1  (i1_data),
    .i_sel (w_pick),
    .o_d   (w_mux_data)
  );

  // Output slot: load on transfer, empty on drain without refill, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_j     <= SEL_I0;
      r_burst <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_mux_data;
      r_j     <= w_pick;
      r_burst <= w_burst_nxt;
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign j       = r_j;

endmodule

// File: tb/tb_mux2_rr_merge.sv
module tb_mux2_rr_merge;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] i0_data, i1_data, o_data;
  logic             i0_valid, i1_valid, i0_ready, i1_ready;
  logic             o_valid, o_ready, j;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] data;
  } word_t;

  // Reference: words expected in the output slot, last owner and its run length.
  word_t sb_q[$];
  logic  m_last;
  int    m_run;

  always #5 clk = ~clk;

  mux2_rr_merge #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_ready (i0_ready),
    .i1_data  (i1_data),
    .i1_valid (i1_valid),
    .i1_ready (i1_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .j        (j)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    sb_q.delete();
    m_last = 1'b0;
    m_run  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; o_ready = 1'b0;
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'h5E; i1_data = 8'h6F;
    for (int c = 0; c < 2; c++) begin
      mid();
      checks++;
      if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready got %b%b exp 00", i0_ready, i1_ready);
      end
      next_cycle();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || j !== 1'b0) begin
        errors++; $display("FAIL reset_state got v=%b d=%h j=%b exp v=0 d=00 j=0", o_valid, o_data, j);
      end
    end
    rst_n = 1'b1;
    mid();
    checks++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant got %b%b exp 10", i0_ready, i1_ready);
    end
    next_cycle();
    i0_valid = 1'b0; i1_valid = 1'b0;
  endtask

  task automatic test_single_source();
    do_reset();
    o_ready = 1'b1; i0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i1_valid = (k < 3);
      i1_data  = 8'(8'h11 + k);
      mid();
      if (k < 3) begin
        checks++;
        if (i1_ready !== 1'b1 || i0_ready !== 1'b0) begin
          errors++; $display("FAIL single_ready k=%0d got %b%b exp 01", k, i0_ready, i1_ready);
        end
      end
      if (k > 0) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'(8'h10 + k) || j !== 1'b1) begin
          errors++; $display("FAIL single_out k=%0d got v=%b d=%h j=%b exp v=1 d=%h j=1",
                             k, o_valid, o_data, j, 8'(8'h10 + k));
        end
      end
      next_cycle();
    end
    mid();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got %b exp 0", o_valid);
    end
    next_cycle();
  endtask

  // Both channels request continuously; collect n outputs and compare to
  // a plain round-robin-with-quota order.
  task automatic run_both(input logic [7:0] base0, input logic [7:0] base1,
                          input string name);
    int c0, c1, idx;
    logic [7:0] exp_d;
    logic       exp_j;
    c0 = 0; c1 = 0; idx = 0;
    i0_valid = 1'b1; i1_valid = 1'b1; o_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      i0_data = 8'(base0 + c0);
      i1_data = 8'(base1 + c1);
      mid();
      checks++;
      if (i0_ready && i1_ready) begin
        errors++; $display("FAIL %s_onehot cyc=%0d got both ready exp one", name, cyc);
      end
      if (o_valid && idx < 9) begin
        exp_j = 1'((idx / MAX_BURST) % 2);
        exp_d = exp_j ? 8'(base1 + (idx / (2 * MAX_BURST)) * MAX_BURST + idx % MAX_BURST)
                      : 8'(base0 + (idx / (2 * MAX_BURST)) * MAX_BURST + idx % MAX_BURST);
        checks++;
        if (o_data !== exp_d || j !== exp_j) begin
          errors++; $display("FAIL %s_order idx=%0d got d=%h j=%b exp d=%h j=%b",
                             name, idx, o_data, j, exp_d, exp_j);
        end
        idx++;
      end
      if (i0_ready) c0++;
      if (i1_ready) c1++;
      next_cycle();
    end
    checks++;
    if (idx != 9) begin
      errors++; $display("FAIL %s_count got %0d exp 9", name, idx);
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
  endtask

  task automatic test_burst_cap();
    do_reset();
    run_both(8'hA0, 8'hB0, "burst");
  endtask

  task automatic test_backpressure();
    do_reset();
    i0_valid = 1'b1; i0_data = 8'h5A; i1_valid = 1'b0; o_ready = 1'b1;
    mid();
    next_cycle();
    o_ready = 1'b0; i0_data = 8'h77; i1_valid = 1'b1; i1_data = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      mid();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h5A || j !== 1'b0 ||
          i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold c=%0d got v=%b d=%h j=%b rdy=%b%b exp v=1 d=5a j=0 rdy=00",
                           c, o_valid, o_data, j, i0_ready, i1_ready);
      end
      next_cycle();
    end
    o_ready = 1'b1;
    mid();
    checks++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release got %b%b exp 10", i0_ready, i1_ready);
    end
    next_cycle();
    i0_valid = 1'b0; i1_valid = 1'b0;
    mid();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h77 || j !== 1'b0) begin
      errors++; $display("FAIL bp_next got v=%b d=%h j=%b exp v=1 d=77 j=0", o_valid, o_data, j);
    end
    next_cycle();
  endtask

  task automatic test_drain();
    do_reset();
    i0_valid = 1'b1; i0_data = 8'h3C; i1_valid = 1'b0; o_ready = 1'b1;
    mid();
    next_cycle();
    i0_valid = 1'b0;
    mid();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      errors++; $display("FAIL drain_word got v=%b d=%h exp v=1 d=3c", o_valid, o_data);
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mid();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h3C || j !== 1'b0) begin
        errors++; $display("FAIL drain_empty c=%0d got v=%b d=%h j=%b exp v=0 d=3c j=0",
                           c, o_valid, o_data, j);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    i0_valid = 1'b1; i1_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      i0_data = 8'(8'h90 + c); i1_data = 8'h99;
      mid();
      checks++;
      if (i0_ready !== 1'b1) begin
        errors++; $display("FAIL mid_pre c=%0d got %b exp 1", c, i0_ready);
      end
      next_cycle();
    end
    rst_n = 1'b0;
    mid();
    checks++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ready got %b%b exp 00", i0_ready, i1_ready);
    end
    next_cycle();
    rst_n = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || j !== 1'b0) begin
      errors++; $display("FAIL mid_rst_state got v=%b j=%b exp v=0 j=0", o_valid, j);
    end
    run_both(8'hD0, 8'hE0, "midrst");
  endtask

  task automatic test_random();
    logic acc0, acc1, exp_v, free, pick, pvalid;
    word_t w;
    do_reset();
    acc0 = 1'b1; acc1 = 1'b1;
    i0_valid = 1'b0; i1_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Producers hold their word until it is accepted.
      if (!i0_valid || acc0) begin
        i0_valid = ($urandom_range(0, 3) != 0); i0_data = 8'($urandom);
      end
      if (!i1_valid || acc1) begin
        i1_valid = ($urandom_range(0, 3) != 0); i1_data = 8'($urandom);
      end
      o_ready = ($urandom_range(0, 3) != 0);
      mid();
      exp_v = (sb_q.size() != 0);
      checks++;
      if (o_valid !== exp_v) begin
        errors++; $display("FAIL rand_valid cyc=%0d got %b exp %b", cyc, o_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (o_data !== sb_q[0].data || j !== sb_q[0].src) begin
          errors++; $display("FAIL rand_data cyc=%0d got d=%h j=%b exp d=%h j=%b",
                             cyc, o_data, j, sb_q[0].data, sb_q[0].src);
        end
      end
      free = !exp_v || o_ready;
      if (i0_valid && i1_valid) pick = (m_run >= int'(MAX_BURST)) ? !m_last : m_last;
      else if (i0_valid)        pick = 1'b0;
      else if (i1_valid)        pick = 1'b1;
      else                      pick = m_last;
      checks++;
      if (i0_ready !== (free && !pick) || i1_ready !== (free && pick)) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b%b exp %b%b",
                           cyc, i0_ready, i1_ready, free && !pick, free && pick);
      end
      pvalid = pick ? i1_valid : i0_valid;
      acc0 = i0_valid && free && !pick;
      acc1 = i1_valid && free && pick;
      if (exp_v && o_ready) void'(sb_q.pop_front());
      if (free && pvalid) begin
        w.src  = pick;
        w.data = pick ? i1_data : i0_data;
        sb_q.push_back(w);
        m_run  = (pick == m_last) ? ((m_run + 1 > int'(MAX_BURST)) ? int'(MAX_BURST) : m_run + 1) : 1;
        m_last = pick;
      end
      next_cycle();
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; o_ready = 1'b0;
    i0_valid = 1'b0; i1_valid = 1'b0; i0_data = '0; i1_data = '0;
    m_last = 1'b0; m_run = 0;
    #1;
    test_reset();
    test_single_source();
    test_burst_cap();
    test_backpressure();
    test_drain();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
